parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that feeds the 8-bit parity checker stage. It deserialises start/data/parity/stop frames from a one-bit line and recomputes parity with the same four coverage modes and polarity control the checker uses. It compares the result with the received parity bit and presents each byte with error flags and a saturating error count. The parity function lives in its own small sub-module, so the checker stage and this block stay bit-exact.

## Interface
- `CNT_W`, 8, width of the saturating error counter
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `sin`  in  1  serial data line
- `sin_valid`  in  1  `sin` holds a bit this cycle; no bit is consumed when low
- `chk`  in  2  parity coverage: 00 = D[7:4], 01 = D[0,2,4,6], 10 = D[1,3,5,7], 11 = D[7:0]
- `even`  in  1  0 = expected parity is XOR of covered bits; 1 = its inverse
- `clr_cnt`  in  1  synchronous clear of `err_cnt`
- `dout`  out  8  last received data byte
- `dout_valid`  out  1  one-cycle pulse: a new frame result is present
- `par_err`  out  1  parity mismatch for the frame flagged by `dout_valid`
- `frame_err`  out  1  stop bit was 0 for the frame flagged by `dout_valid`
- `err_cnt`  out  CNT_W  count of frames with `par_err` or `frame_err`; saturates at all-ones
- `busy`  out  1  state is not IDLE

## Operation
- Frame, one bit per accepted cycle (`sin_valid` = 1): start bit 0, then D0..D7 (LSB first), then the parity bit P, then stop bit 1.
- States:
  - IDLE: accepted `sin` = 0 → DATA, bit index = 0, `chk`/`even` latched; accepted `sin` = 1 → stay in IDLE (line idle).
  - DATA: shift the accepted bit into position [index]; after index 7 → PAR.
  - PAR: store P → STOP.
  - STOP: evaluate, then → IDLE.
- Cycles with `sin_valid` = 0 hold all state and the bit index (stall).
- Parity: the expected parity is the parity function of the assembled byte under the latched `chk`/`even`. A change of `chk`/`even` mid-frame has no effect on that frame.
- Set on the STOP evaluation:
  - `par_err` = (P ≠ expected)
  - `frame_err` = (stop bit == 0)
- Data is always delivered, even when an error is flagged.
- `err_cnt` increments by 1 when `dout_valid` is asserted with either error set. It holds at 2^CNT_W−1.
- `clr_cnt` zeroes `err_cnt`. If `clr_cnt` and an erroneous frame occur in the same cycle, the clear wins and the result is 0.
- `dout`, `par_err` and `frame_err` hold until the next `dout_valid`.

## Timing
- Reset (asynchronous, `rst_n` low): state IDLE, bit index 0, and every output 0: `dout` = 0, `dout_valid` = 0, `par_err` = 0, `frame_err` = 0, `err_cnt` = 0, `busy` = 0.
- Reset mid-frame discards the partial frame; no `dout_valid` follows.
- Latency: `dout_valid` rises on the clock edge that accepts the stop bit (registered output, visible the following cycle) and lasts exactly one cycle.
- `err_cnt` reflects the frame in the same cycle `dout_valid` is high.
- Minimum frame: 11 accepted cycles. A new start bit is accepted in the cycle directly after the stop bit, so back-to-back frames are supported.
- `busy` goes high the cycle after the start bit is accepted and low the cycle after the stop bit is accepted.

## Structure
- Shared package holds:
  - `chk` encodings as named constants: `CHK_HI_NIB`, `CHK_EVEN_IDX`, `CHK_ODD_IDX`, `CHK_ALL`
  - the state enum: IDLE, DATA, PAR, STOP
  - the frame length constant (11)
- Sub-module `parity_calc`: combinational; inputs `d[7:0]`, `chk[1:0]`, `even`; output `p`. The checker stage and this block both use it.
- This block holds the FSM, the 3-bit bit index, the shift register, the latched mode, and the output/counter registers.

## Test plan
- Frame with byte 0xA5, chk = 11, even = 0 (expected parity 0) sent with P = 0, stop = 1 → `dout` = 0xA5, `dout_valid` pulses once, `par_err` = 0, `frame_err` = 0, `err_cnt` = 0.
- Byte 0xF0, chk = 00, even = 1 (expected parity 1) sent with P = 0 → `par_err` = 1, `err_cnt` = 1. Then byte 0x0F, chk = 01, even = 0 (expected parity 0) with P = 0 and stop = 0 → `par_err` = 0, `frame_err` = 1, `err_cnt` = 2.
- Byte 0x3C with `sin_valid` low for 5 random cycles between bits, and `chk` toggled mid-frame → result identical to the unstalled frame under the mode latched at the start bit.
- Reset pulsed after D3 of a frame → all outputs 0, no `dout_valid`. A following clean frame carrying 0x81 is received correctly.
- CNT_W = 2 with 5 bad frames → `err_cnt` sequence 1, 2, 3, 3, 3. `clr_cnt` asserted in the same cycle as a 6th bad frame → `err_cnt` = 0.
- Two back-to-back frames 0x55 then 0xAA with no idle bits, chk = 10, even = 0 → two `dout_valid` pulses exactly 11 cycles apart, correct bytes, no errors.

Source files
------------

// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the serial parity frame receiver and the parity checker stage.
// Coverage encodings must stay identical in both users of parity_calc.
package parity_frame_rx_pkg;

    localparam logic [1:0] CHK_HI_NIB   = 2'b00;
    localparam logic [1:0] CHK_EVEN_IDX = 2'b01;
    localparam logic [1:0] CHK_ODD_IDX  = 2'b10;
    localparam logic [1:0] CHK_ALL      = 2'b11;

    localparam int FRAME_LEN = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

endpackage

// File: rtl/parity_frame_rx_parity_calc.sv
// Combinational parity over a selectable subset of a byte, with polarity control.
// Shared with the checker stage so both compute bit-exact parity.
module parity_calc
    import parity_frame_rx_pkg::*;
(
    input  logic [7:0] d,
    input  logic [1:0] chk,
    input  logic       even,
    output logic       p
);

    logic [7:0] mask;

    always_comb begin
        mask = 8'hFF;
        unique case (chk)
            CHK_HI_NIB:   mask = 8'hF0;
            CHK_EVEN_IDX: mask = 8'h55;
            CHK_ODD_IDX:  mask = 8'hAA;
            CHK_ALL:      mask = 8'hFF;
            default:      mask = 8'hFF;
        endcase
        p = (^(d & mask)) ^ even;
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop frame receiver with parity and framing checks
// and a saturating error counter.
//
// state | meaning
// IDLE  | waiting for a start bit (0) on an accepted cycle
// DATA  | shifting in D0..D7, LSB first
// PAR   | capturing the received parity bit
// STOP  | evaluating the stop bit and publishing the result
module parity_frame_rx
    import parity_frame_rx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic [1:0]       chk,
    input  logic             even,
    input  logic             clr_cnt,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             par_err,
    output logic             frame_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    rx_state_t        state, state_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [1:0]       chk_lat, chk_lat_nxt;
    logic             even_lat, even_lat_nxt;
    logic             p_bit, p_bit_nxt;
    logic [7:0]       dout_nxt;
    logic             dout_valid_nxt;
    logic             par_err_nxt;
    logic             frame_err_nxt;
    logic [CNT_W-1:0] err_cnt_nxt;
    logic             p_exp;

    // Mode is latched at the start bit so mid-frame changes of chk/even are ignored.
    parity_calc u_parity_calc (
        .d    (shreg),
        .chk  (chk_lat),
        .even (even_lat),
        .p    (p_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            chk_lat    <= 2'b00;
            even_lat   <= 1'b0;
            p_bit      <= 1'b0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            par_err    <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            chk_lat    <= chk_lat_nxt;
            even_lat   <= even_lat_nxt;
            p_bit      <= p_bit_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            par_err    <= par_err_nxt;
            frame_err  <= frame_err_nxt;
            err_cnt    <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        chk_lat_nxt    = chk_lat;
        even_lat_nxt   = even_lat;
        p_bit_nxt      = p_bit;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        par_err_nxt    = par_err;
        frame_err_nxt  = frame_err;

        if (sin_valid) begin
            unique case (state)
                IDLE: begin
                    if (!sin) begin
                        state_nxt    = DATA;
                        bit_idx_nxt  = 3'd0;
                        chk_lat_nxt  = chk;
                        even_lat_nxt = even;
                    end
                end
                DATA: begin
                    shreg_nxt[bit_idx] = sin;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = PAR;
                    end
                end
                PAR: begin
                    p_bit_nxt = sin;
                    state_nxt = STOP;
                end
                STOP: begin
                    dout_nxt       = shreg;
                    dout_valid_nxt = 1'b1;
                    par_err_nxt    = (p_bit != p_exp);
                    frame_err_nxt  = !sin;
                    state_nxt      = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Clear has priority over a simultaneous erroneous frame.
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (clr_cnt) begin
            err_cnt_nxt = '0;
        end else if (dout_valid_nxt && (par_err_nxt || frame_err_nxt) && (err_cnt != '1)) begin
            err_cnt_nxt = err_cnt + CNT_W'(1);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed table, corner sequences and random frames.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b1;
    logic       sin_valid = 1'b0;
    logic [1:0] chk = 2'b00;
    logic       even = 1'b0;
    logic       clr_cnt = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    parity_frame_rx #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .chk(chk), .even(even),
        .clr_cnt(clr_cnt), .dout(dout_a), .dout_valid(dv_a), .par_err(pe_a), .frame_err(fe_a),
        .err_cnt(cnt_a), .busy(busy_a)
    );

    parity_frame_rx #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .chk(chk), .even(even),
        .clr_cnt(clr_cnt), .dout(dout_b), .dout_valid(dv_b), .par_err(pe_b), .frame_err(fe_b),
        .err_cnt(cnt_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         cnt8;
        int         cnt2;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   pulses = 0;
    int   pulse_cyc[$];
    int   m8 = 0;
    int   m2 = 0;

    // Every dout_valid pulse is matched in order against the expectation queue.
    always @(negedge clk) begin
        if (dv_a) begin
            pulses++;
            pulse_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                check("unexpected_dout_valid", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("dout", int'(dout_a), int'(mon_e.d));
                check("par_err", int'(pe_a), int'(mon_e.pe));
                check("frame_err", int'(fe_a), int'(mon_e.fe));
                check("err_cnt", int'(cnt_a), mon_e.cnt8);
                check("err_cnt_w2", int'(cnt_b), mon_e.cnt2);
                check("dout_valid_w2", int'(dv_b), 1);
                check("dout_w2", int'(dout_b), int'(mon_e.d));
            end
        end
    end

    function automatic logic exp_parity(input logic [7:0] d, input logic [1:0] c, input logic e);
        logic [7:0] mask;
        int ones;
        case (c)
            2'b00:   mask = 8'hF0;
            2'b01:   mask = 8'h55;
            2'b10:   mask = 8'hAA;
            default: mask = 8'hFF;
        endcase
        ones = $countones(d & mask);
        return ((ones % 2) == 1) != e;
    endfunction

    // Reference model: expected frame result and both saturating counters.
    task automatic model_frame(input logic [7:0] d, input logic [1:0] c, input logic e,
                               input logic p, input logic stop, input logic clr, output exp_t x);
        x.d  = d;
        x.pe = (p != exp_parity(d, c, e));
        x.fe = !stop;
        if (clr) begin
            m8 = 0;
            m2 = 0;
        end else if (x.pe || x.fe) begin
            if (m8 < 255) m8++;
            if (m2 < 3) m2++;
        end
        x.cnt8 = m8;
        x.cnt2 = m2;
    endtask

    task automatic idle(input int n, input bit rand_valid);
        repeat (n) begin
            @(negedge clk);
            sin       = 1'b1;
            sin_valid = rand_valid ? 1'($urandom_range(1, 0)) : 1'b0;
            clr_cnt   = 1'b0;
        end
    endtask

    // Drives nbits bits of a frame; 'stalls' invalid cycles are scattered between bits.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] c, input logic e,
                              input logic p, input logic stop, input int stalls,
                              input bit toggle, input bit clr, input int nbits);
        logic bits[11];
        int   gap[11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = p;
        bits[10] = stop;
        for (int i = 0; i < 11; i++) gap[i] = 0;
        for (int k = 0; k < stalls; k++) gap[$urandom_range(10, 1)]++;
        for (int i = 0; i < nbits; i++) begin
            repeat (gap[i]) begin
                @(negedge clk);
                sin_valid = 1'b0;
                sin       = 1'($urandom_range(1, 0));
                clr_cnt   = 1'b0;
                if (toggle) begin
                    chk  = 2'($urandom_range(3, 0));
                    even = 1'($urandom_range(1, 0));
                end
            end
            @(negedge clk);
            sin       = bits[i];
            sin_valid = 1'b1;
            clr_cnt   = (i == 10) && clr;
            if (i == 0) begin
                chk  = c;
                even = e;
            end else if (toggle) begin
                chk  = 2'($urandom_range(3, 0));
                even = 1'($urandom_range(1, 0));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b1;
        clr_cnt   = 1'b0;
        expq.delete();
        m8 = 0;
        m2 = 0;
        @(negedge clk);
        check("rst_dout", int'(dout_a), 0);
        check("rst_dout_valid", int'(dv_a), 0);
        check("rst_par_err", int'(pe_a), 0);
        check("rst_frame_err", int'(fe_a), 0);
        check("rst_err_cnt", int'(cnt_a), 0);
        check("rst_err_cnt_w2", int'(cnt_b), 0);
        check("rst_busy", int'(busy_a), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        logic       e;
        logic       p;
        logic       stop;
        int         stalls;
        bit         toggle;
        logic       exp_pe;
        logic       exp_fe;
        int         exp_cnt;
    } vec_t;

    vec_t vt[5];
    exp_t x;
    exp_t x2;
    int   p0;
    int   pc0;
    logic [7:0] rd;
    logic [1:0] rc;
    logic       re, rp, rs, rclr;
    int   sat_seq[5];

    initial begin
        vt[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0};
        vt[1] = '{8'hF0, 2'b00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1};
        vt[2] = '{8'h0F, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2};
        vt[3] = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 2};
        vt[4] = '{8'h3C, 2'b11, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0, 3};
        sat_seq = '{1, 2, 3, 3, 3};

        do_reset();
        idle(2, 1'b0);

        for (int i = 0; i < 5; i++) begin
            model_frame(vt[i].d, vt[i].c, vt[i].e, vt[i].p, vt[i].stop, 1'b0, x);
            x.pe   = vt[i].exp_pe;
            x.fe   = vt[i].exp_fe;
            x.cnt8 = vt[i].exp_cnt;
            expq.push_back(x);
            p0 = pulses;
            send_frame(vt[i].d, vt[i].c, vt[i].e, vt[i].p, vt[i].stop, vt[i].stalls,
                       vt[i].toggle, 1'b0, 11);
            idle(3, 1'b0);
            check("table_pulse_count", pulses - p0, 1);
            check("table_busy_idle", int'(busy_a), 0);
            check("table_dout_hold", int'(dout_a), int'(vt[i].d));
        end

        // Reset after D3: partial frame is discarded.
        p0 = pulses;
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 5);
        idle(1, 1'b0);
        check("busy_mid_frame", int'(busy_a), 1);
        do_reset();
        idle(12, 1'b0);
        check("no_pulse_after_reset", pulses - p0, 0);
        model_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, x);
        expq.push_back(x);
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 11);
        idle(3, 1'b0);
        check("post_reset_frame_pulse", pulses - p0, 1);

        // Saturation on the 2-bit counter, then clear beating a bad frame.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom_range(255, 0));
            rc = 2'($urandom_range(3, 0));
            re = 1'($urandom_range(1, 0));
            rp = !exp_parity(rd, rc, re);
            model_frame(rd, rc, re, rp, 1'b1, (i == 5), x);
            x.pe = 1'b1;
            if (i < 5) begin
                x.cnt2 = sat_seq[i];
                x.cnt8 = i + 1;
            end else begin
                x.cnt2 = 0;
                x.cnt8 = 0;
            end
            expq.push_back(x);
            send_frame(rd, rc, re, rp, 1'b1, 0, 1'b0, (i == 5), 11);
            idle(2, 1'b0);
        end
        check("sat_queue_drained", expq.size(), 0);

        // Back-to-back frames with no idle bits.
        pc0 = pulse_cyc.size();
        model_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, x);
        model_frame(8'hAA, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, x2);
        x.pe = 1'b0; x.fe = 1'b0;
        x2.pe = 1'b0; x2.fe = 1'b0;
        expq.push_back(x);
        expq.push_back(x2);
        send_frame(8'h55, 2'b10, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 11);
        send_frame(8'hAA, 2'b10, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 11);
        idle(3, 1'b0);
        check("b2b_pulses", pulse_cyc.size() - pc0, 2);
        if (pulse_cyc.size() - pc0 == 2)
            check("b2b_spacing", pulse_cyc[pc0+1] - pulse_cyc[pc0], 11);

        // Random frames against the reference model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rd   = 8'($urandom_range(255, 0));
            rc   = 2'($urandom_range(3, 0));
            re   = 1'($urandom_range(1, 0));
            rp   = exp_parity(rd, rc, re) ^ ($urandom_range(3, 0) == 0);
            rs   = ($urandom_range(4, 0) != 0);
            rclr = ($urandom_range(7, 0) == 0);
            model_frame(rd, rc, re, rp, rs, rclr, x);
            expq.push_back(x);
            send_frame(rd, rc, re, rp, rs, $urandom_range(3, 0), 1'($urandom_range(1, 0)), rclr, 11);
            idle($urandom_range(2, 0), 1'b1);
        end
        idle(3, 1'b0);
        check("final_queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
